sdram_cmd_arbiter: RTL and testbench

Arbiter and sequencer for the shared SDRAM command/address bus. It sits between the SDRAM init, auto-refresh, write and read sub-modules and the SDRAM pins. It owns the periodic refresh timer, grants the bus to one sub-module at a time, and muxes that owner's cmd/addr/bank onto the pins. Refresh has absolute priority; write and read share the bus round-robin.

---
 rtl/sdram_cmd_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_sdram_cmd_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_arbiter.sv
// Shared SDRAM command-bus arbiter: owns the refresh timer, grants the bus to
// init / refresh / write / read and muxes the owner's command onto the pins.
module sdram_cmd_arbiter #(
    parameter int          REF_CYCLES = 750,
    parameter int          ADDR_W     = 12,
    parameter logic [3:0]  CMD_NOP    = 4'b0111
) (
    input  logic              s_clk,
    input  logic              s_rst_n,
    input  logic              init_done,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              aref_end,
    input  logic              wr_req,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_bank,
    input  logic              wr_end,
    input  logic              rd_req,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_bank,
    input  logic              rd_end,
    output logic              aref_req,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [1:0]        sdram_bank,
    output logic              ref_overrun
);

    localparam int CNT_W = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    state_t             state_q;
    state_t             rr_last_q;
    logic               aref_en_q;
    logic               wr_en_q;
    logic               rd_en_q;
    logic               init_done_q;
    logic [CNT_W-1:0]   ref_cnt_q;
    logic [CNT_W-1:0]   ref_cnt_d;
    logic               aref_req_q;
    logic               aref_req_d;
    logic               ref_overrun_q;
    logic               ref_overrun_d;
    logic               ref_tc_s;

    // Remember that initialisation has completed; a later drop of init_done is ignored.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= init_done_q | init_done;
        end
    end

    assign ref_tc_s = init_done_q && (ref_cnt_q == CNT_W'(REF_CYCLES - 1));

    // Free-running refresh interval timer plus pending/overrun flags.
    always_comb begin
        ref_cnt_d     = ref_cnt_q;
        aref_req_d    = aref_req_q;
        ref_overrun_d = ref_overrun_q | (ref_tc_s & aref_req_q);
        if (!init_done_q) begin
            ref_cnt_d = '0;
        end else if (ref_tc_s) begin
            ref_cnt_d = '0;
        end else begin
            ref_cnt_d = ref_cnt_q + CNT_W'(1);
        end
        // A new interval expiring outranks a completion in the same cycle.
        if (ref_tc_s) begin
            aref_req_d = 1'b1;
        end else if ((state_q == ST_AREF) && aref_end) begin
            aref_req_d = 1'b0;
        end else begin
            aref_req_d = aref_req_q;
        end
    end

    // Refresh timer and flag registers.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            ref_cnt_q     <= '0;
            aref_req_q    <= 1'b0;
            ref_overrun_q <= 1'b0;
        end else begin
            ref_cnt_q     <= ref_cnt_d;
            aref_req_q    <= aref_req_d;
            ref_overrun_q <= ref_overrun_d;
        end
    end

    // Bus ownership FSM with registered grants and round-robin memory.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= ST_INIT;
            rr_last_q <= ST_READ;
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_done) begin
                        state_q <= ST_ARBIT;
                    end
                end
                ST_ARBIT: begin
                    if (aref_req_q) begin
                        state_q   <= ST_AREF;
                        aref_en_q <= 1'b1;
                    end else if (wr_req && (!rd_req || (rr_last_q == ST_READ))) begin
                        state_q   <= ST_WRITE;
                        rr_last_q <= ST_WRITE;
                        wr_en_q   <= 1'b1;
                    end else if (rd_req) begin
                        state_q   <= ST_READ;
                        rr_last_q <= ST_READ;
                        rd_en_q   <= 1'b1;
                    end
                end
                ST_AREF: begin
                    if (aref_end) begin
                        state_q   <= ST_ARBIT;
                        aref_en_q <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (wr_end) begin
                        state_q <= ST_ARBIT;
                        wr_en_q <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (rd_end) begin
                        state_q <= ST_ARBIT;
                        rd_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_INIT;
                    aref_en_q <= 1'b0;
                    wr_en_q   <= 1'b0;
                    rd_en_q   <= 1'b0;
                end
            endcase
        end
    end

    // Pin mux: the current owner drives the bus with no added latency.
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = 2'b00;
        case (state_q)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_ARBIT: begin
                sdram_cmd  = CMD_NOP;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
            end
        endcase
    end

    assign aref_req    = aref_req_q;
    assign aref_en     = aref_en_q;
    assign wr_en       = wr_en_q;
    assign rd_en       = rd_en_q;
    assign ref_overrun = ref_overrun_q;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Randomised self-checking bench for sdram_cmd_arbiter against a bus-ownership model.
module tb_sdram_cmd_arbiter;

    localparam int REF    = 750;
    localparam int ADDR_W = 12;
    localparam int O_INIT = 0, O_IDLE = 1, O_REF = 2, O_WR = 3, O_RD = 4;

    logic              s_clk = 1'b0;
    logic              s_rst_n = 1'b0;
    logic              init_done = 1'b0;
    logic [3:0]        init_cmd = 4'd0;
    logic [ADDR_W-1:0] init_addr = '0;
    logic [3:0]        aref_cmd = 4'd0;
    logic [ADDR_W-1:0] aref_addr = '0;
    logic              aref_end = 1'b0;
    logic              wr_req = 1'b0;
    logic [3:0]        wr_cmd = 4'd0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [1:0]        wr_bank = 2'd0;
    logic              wr_end = 1'b0;
    logic              rd_req = 1'b0;
    logic [3:0]        rd_cmd = 4'd0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [1:0]        rd_bank = 2'd0;
    logic              rd_end = 1'b0;
    logic              aref_req, aref_en, wr_en, rd_en, ref_overrun;
    logic [3:0]        sdram_cmd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [1:0]        sdram_bank;

    int checks = 0;
    int failures = 0;

    always #5 s_clk = ~s_clk;

    sdram_cmd_arbiter #(.REF_CYCLES(REF), .ADDR_W(ADDR_W), .CMD_NOP(4'b0111)) dut (
        .s_clk(s_clk), .s_rst_n(s_rst_n), .init_done(init_done),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_end(aref_end),
        .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_end(wr_end),
        .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank), .rd_end(rd_end),
        .aref_req(aref_req), .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
        .ref_overrun(ref_overrun)
    );

    logic [22:0] dut_out;
    assign dut_out = {aref_req, aref_en, wr_en, rd_en, ref_overrun, sdram_cmd, sdram_addr, sdram_bank};

    // Reference model: who owns the bus, edges elapsed since init, refresh bookkeeping.
    int   m_owner;
    int   m_since;
    bit   m_started, m_pend, m_ovr, m_last_wr;
    logic m_tick;
    assign m_tick = m_started && (((m_since + 1) % REF) == 0);

    always @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            m_owner <= O_INIT; m_since <= 0; m_started <= 1'b0;
            m_pend <= 1'b0; m_ovr <= 1'b0; m_last_wr <= 1'b0;
        end else begin
            if (m_started) m_since <= m_since + 1;
            else if (init_done) begin m_started <= 1'b1; m_since <= 0; end
            if (m_tick) begin
                m_pend <= 1'b1;
                if (m_pend) m_ovr <= 1'b1;
            end else if (m_owner == O_REF && aref_end) m_pend <= 1'b0;
            case (m_owner)
                O_INIT: if (init_done) m_owner <= O_IDLE;
                O_IDLE: begin
                    if (m_pend) m_owner <= O_REF;
                    else if (wr_req && (!rd_req || !m_last_wr)) begin m_owner <= O_WR; m_last_wr <= 1'b1; end
                    else if (rd_req) begin m_owner <= O_RD; m_last_wr <= 1'b0; end
                end
                O_REF:  if (aref_end) m_owner <= O_IDLE;
                O_WR:   if (wr_end) m_owner <= O_IDLE;
                O_RD:   if (rd_end) m_owner <= O_IDLE;
                default: m_owner <= O_INIT;
            endcase
        end
    end

    function automatic logic [22:0] model_out();
        logic [3:0] c; logic [ADDR_W-1:0] a; logic [1:0] b;
        c = 4'b0111; a = '0; b = 2'd0;
        case (m_owner)
            O_INIT: begin c = init_cmd; a = init_addr; end
            O_REF:  begin c = aref_cmd; a = aref_addr; end
            O_WR:   begin c = wr_cmd; a = wr_addr; b = wr_bank; end
            O_RD:   begin c = rd_cmd; a = rd_addr; b = rd_bank; end
            default: ;
        endcase
        return {m_pend, m_owner == O_REF, m_owner == O_WR, m_owner == O_RD, m_ovr, c, a, b};
    endfunction

    task automatic rand_buses();
        init_cmd = 4'($urandom); init_addr = ADDR_W'($urandom);
        aref_cmd = 4'($urandom); aref_addr = ADDR_W'($urandom);
        wr_cmd = 4'($urandom); wr_addr = ADDR_W'($urandom); wr_bank = 2'($urandom);
        rd_cmd = 4'($urandom); rd_addr = ADDR_W'($urandom); rd_bank = 2'($urandom);
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0;
        repeat (3) @(negedge s_clk);
        rand_buses(); #1;
        checks++;
        if (dut_out !== model_out()) begin failures++; $display("FAIL reset_state got=%h want=%h", dut_out, model_out()); end
        checks++;
        if ({aref_req, aref_en, wr_en, rd_en, ref_overrun} !== 5'b00000 || sdram_cmd !== init_cmd)
            begin failures++; $display("FAIL reset_flags got=%b cmd=%h want=00000 cmd=%h", {aref_req, aref_en, wr_en, rd_en, ref_overrun}, sdram_cmd, init_cmd); end
        s_rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge s_clk); rand_buses(); #1;
            checks++;
            if (dut_out !== model_out()) begin failures++; $display("FAIL init_hold cyc=%0d got=%h want=%h", i, dut_out, model_out()); end
        end
        checks++;
        if (sdram_cmd !== init_cmd || sdram_addr !== init_addr || sdram_bank !== 2'd0)
            begin failures++; $display("FAIL init_pins got=%h/%h want=%h/%h", sdram_cmd, sdram_addr, init_cmd, init_addr); end
    endtask

    task automatic test_init();
        @(negedge s_clk); init_done = 1'b1;
        @(posedge s_clk);
        @(negedge s_clk); rand_buses(); #1;
        checks++;
        if (sdram_cmd !== 4'b0111 || sdram_addr !== 12'd0 || {aref_en, wr_en, rd_en} !== 3'b000)
            begin failures++; $display("FAIL arbit_nop got cmd=%h addr=%h en=%b want 7/000/000", sdram_cmd, sdram_addr, {aref_en, wr_en, rd_en}); end
        checks++;
        if (dut_out !== model_out()) begin failures++; $display("FAIL arbit_model got=%h want=%h", dut_out, model_out()); end
    endtask

    task automatic test_refresh();
        int n = 0;
        bit seen = 1'b0;
        while (n < REF + 20 && !seen) begin
            @(posedge s_clk); n++;
            @(negedge s_clk);
            if (n == 5) init_done = 1'b0;
            rand_buses(); #1;
            checks++;
            if (dut_out !== model_out()) begin failures++; $display("FAIL refresh_idle n=%0d got=%h want=%h", n, dut_out, model_out()); end
            if (aref_req === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != REF) begin failures++; $display("FAIL refresh_interval got=%0d seen=%0d want=%0d", n, seen, REF); end
        @(negedge s_clk); rand_buses(); #1;
        checks++;
        if (aref_en !== 1'b1 || sdram_cmd !== aref_cmd || sdram_bank !== 2'd0)
            begin failures++; $display("FAIL aref_grant got en=%b cmd=%h want en=1 cmd=%h", aref_en, sdram_cmd, aref_cmd); end
        repeat (3) begin
            @(negedge s_clk); rand_buses(); #1;
            checks++;
            if (dut_out !== model_out()) begin failures++; $display("FAIL aref_hold got=%h want=%h", dut_out, model_out()); end
        end
        @(negedge s_clk); aref_end = 1'b1;
        @(negedge s_clk); aref_end = 1'b0; #1;
        checks++;
        if (aref_en !== 1'b0 || aref_req !== 1'b0 || sdram_cmd !== 4'b0111)
            begin failures++; $display("FAIL aref_done got en=%b req=%b cmd=%h want 0/0/7", aref_en, aref_req, sdram_cmd); end
    endtask

    task automatic test_round_robin();
        int grants[$];
        int since = 100;
        int cur = O_IDLE;
        bit prev_any = 1'b0;
        int budget = 0;
        wr_req = 1'b1; rd_req = 1'b1;
        while (!(grants.size() >= 4 && since > 9) && budget < 400) begin
            @(negedge s_clk); budget++;
            rand_buses();
            wr_end = (cur == O_WR && since == 8);
            rd_end = (cur == O_RD && since == 8);
            #1;
            checks++;
            if (dut_out !== model_out()) begin failures++; $display("FAIL rr_model got=%h want=%h", dut_out, model_out()); end
            if ((wr_en === 1'b1 && cur != O_WR) || (rd_en === 1'b1 && cur != O_RD)) begin
                cur = (wr_en === 1'b1) ? O_WR : O_RD;
                grants.push_back(cur);
                since = 0;
                checks++;
                if (prev_any) begin failures++; $display("FAIL rr_gap got no NOP before grant %0d want NOP", grants.size()); end
            end else begin
                since++;
                if (wr_en !== 1'b1 && rd_en !== 1'b1) cur = O_IDLE;
            end
            prev_any = (wr_en === 1'b1) || (rd_en === 1'b1) || (aref_en === 1'b1);
        end
        wr_end = 1'b0; rd_end = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        checks++;
        if (grants.size() < 4 || grants[0] != O_WR || grants[1] != O_RD || grants[2] != O_WR || grants[3] != O_RD)
            begin failures++; $display("FAIL rr_order got n=%0d want W,R,W,R", grants.size()); end
    endtask

    task automatic test_no_preempt();
        int budget = 0;
        while (!(m_owner == O_IDLE && !m_pend && (m_since % REF) == REF - 3) && budget < 2000) begin
            @(negedge s_clk); budget++; rand_buses(); #1;
        end
        checks++;
        if (budget >= 2000) begin failures++; $display("FAIL preempt_align got timeout want aligned"); end
        wr_req = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge s_clk); rand_buses(); #1;
            checks++;
            if (dut_out !== model_out()) begin failures++; $display("FAIL preempt_model cyc=%0d got=%h want=%h", cyc, dut_out, model_out()); end
            if (cyc == 2) begin
                checks++;
                if (aref_req !== 1'b0 || wr_en !== 1'b1) begin failures++; $display("FAIL preempt_c2 got req=%b wr_en=%b want 0/1", aref_req, wr_en); end
            end
            if (cyc == 3) begin
                checks++;
                if (aref_req !== 1'b1 || wr_en !== 1'b1 || aref_en !== 1'b0) begin failures++; $display("FAIL preempt_c3 got req=%b wr=%b aref=%b want 1/1/0", aref_req, wr_en, aref_en); end
            end
        end
        @(negedge s_clk); wr_end = 1'b1; rd_req = 1'b1; #1;
        @(negedge s_clk); wr_end = 1'b0; #1;
        checks++;
        if ({aref_en, wr_en, rd_en} !== 3'b000 || sdram_cmd !== 4'b0111) begin failures++; $display("FAIL preempt_gap got en=%b cmd=%h want 000/7", {aref_en, wr_en, rd_en}, sdram_cmd); end
        @(negedge s_clk); #1;
        checks++;
        if ({aref_en, wr_en, rd_en} !== 3'b100) begin failures++; $display("FAIL preempt_aref got en=%b want 100", {aref_en, wr_en, rd_en}); end
        @(negedge s_clk); aref_end = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        @(negedge s_clk); aref_end = 1'b0; #1;
        checks++;
        if (dut_out !== model_out()) begin failures++; $display("FAIL preempt_after got=%h want=%h", dut_out, model_out()); end
    endtask

    task automatic test_overrun();
        int n = 0;
        #1;
        checks++;
        if (ref_overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b want=0", ref_overrun); end
        while (!m_ovr && n < 2 * REF + 20) begin
            @(negedge s_clk); n++; rand_buses(); #1;
            checks++;
            if (dut_out !== model_out()) begin failures++; $display("FAIL overrun_model n=%0d got=%h want=%h", n, dut_out, model_out()); end
        end
        checks++;
        if (ref_overrun !== 1'b1 || aref_en !== 1'b1) begin failures++; $display("FAIL overrun_set got ovr=%b en=%b want 1/1", ref_overrun, aref_en); end
        @(negedge s_clk); aref_end = 1'b1;
        @(negedge s_clk); aref_end = 1'b0;
        repeat (2) @(negedge s_clk);
        #1;
        checks++;
        if (ref_overrun !== 1'b1 || aref_req !== 1'b0 || aref_en !== 1'b0) begin failures++; $display("FAIL overrun_sticky got ovr=%b req=%b en=%b want 1/0/0", ref_overrun, aref_req, aref_en); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge s_clk);
            rand_buses();
            if ($urandom_range(0, 7) == 0) wr_req = ~wr_req;
            if ($urandom_range(0, 7) == 0) rd_req = ~rd_req;
            wr_end = ($urandom_range(0, 5) == 0);
            rd_end = ($urandom_range(0, 5) == 0);
            aref_end = ($urandom_range(0, 3) == 0);
            init_done = 1'($urandom);
            #1;
            checks++;
            if (dut_out !== model_out()) begin failures++; $display("FAIL random cyc=%0d got=%h want=%h", i, dut_out, model_out()); end
        end
        wr_end = 1'b0; rd_end = 1'b0; aref_end = 1'b0; wr_req = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        int budget = 0;
        rd_req = 1'b1;
        while (rd_en !== 1'b1 && budget < 2000) begin
            @(negedge s_clk); budget++; rand_buses();
            aref_end = (aref_en === 1'b1);
            wr_end = (wr_en === 1'b1);
            #1;
        end
        aref_end = 1'b0; wr_end = 1'b0;
        checks++;
        if (rd_en !== 1'b1) begin failures++; $display("FAIL read_reach got rd_en=%b want 1", rd_en); end
        @(posedge s_clk); #2;
        s_rst_n = 1'b0; #1;
        checks++;
        if (rd_en !== 1'b0 || sdram_cmd !== init_cmd || sdram_addr !== init_addr || sdram_bank !== 2'd0)
            begin failures++; $display("FAIL async_reset got rd_en=%b cmd=%h addr=%h want 0/%h/%h", rd_en, sdram_cmd, sdram_addr, init_cmd, init_addr); end
        checks++;
        if (dut_out !== model_out()) begin failures++; $display("FAIL async_reset_model got=%h want=%h", dut_out, model_out()); end
        @(negedge s_clk); s_rst_n = 1'b1; rd_req = 1'b0; init_done = 1'b0;
        repeat (5) begin
            @(negedge s_clk); rand_buses(); #1;
            checks++;
            if (dut_out !== model_out()) begin failures++; $display("FAIL post_reset got=%h want=%h", dut_out, model_out()); end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_refresh();
        test_round_robin();
        test_no_preempt();
        test_overrun();
        test_random();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
